g_b_serial: RTL

//  Sequential Gray-to-binary decoder; the receive-side counterpart of the b_g binary-to-Gray encoder.

---
 rtl/g_b_serial_pkg.sv | 23 ++
 rtl/g_b_serial_if.sv | 22 ++
 rtl/g_b_serial.sv | 98 +++++++++
 3 files changed

// File: rtl/g_b_serial_pkg.sv
// Shared types and constants for the serial Gray-to-binary decoder.
// gray2bin_ref is a combinational reference decoder intended for benches.
package gray_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int GRAY_WIDTH = 4;

    // Upper bits beyond the real word width must be zero; they then decode to zero.
    function automatic logic [31:0] gray2bin_ref(input logic [31:0] g);
        logic [31:0] b;
        b[31] = g[31];
        for (int i = 30; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/g_b_serial_if.sv
// Handshake bundle between a Gray producer, the decoder and a binary consumer.
// The master modport is the environment side; the slave modport is the decoder.
interface g_b_serial_if #(
    parameter int WIDTH = 4
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] gray_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] bin_out;

    modport master (
        output in_valid, gray_in, out_ready,
        input  in_ready, out_valid, bin_out
    );

    modport slave (
        input  in_valid, gray_in, out_ready,
        output in_ready, out_valid, bin_out
    );
endinterface

// File: rtl/g_b_serial.sv
// Serial Gray-to-binary decoder: one word in flight, MSB resolved first, one bit per clock.
// state | meaning: IDLE = waiting for a word; CONV = resolving bit idx; DONE = result held until taken.
module g_b_serial
    import gray_pkg::*;
#(
    parameter int WIDTH = GRAY_WIDTH
) (
    input  logic          clk,
    input  logic          rst_n,
    g_b_serial_if.slave   bus,
    output logic          busy
);

    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(WIDTH - 1);

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] gray_q;
    logic [WIDTH-1:0] bin_q;
    logic [IDX_W-1:0] idx_q;
    logic             par_q;
    logic             bit_res;

    // Running parity of all Gray bits above and including idx is the binary bit at idx.
    assign bit_res = par_q ^ gray_q[idx_q];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx      = state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        busy          = 1'b0;
        case (state)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    state_nx = CONV;
                end
            end
            CONV: begin
                busy = 1'b1;
                if (idx_q == '0) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                busy          = 1'b1;
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            gray_q <= '0;
            bin_q  <= '0;
            idx_q  <= IDX_TOP;
            par_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        gray_q <= bus.gray_in;
                        bin_q  <= '0;
                        idx_q  <= IDX_TOP;
                        par_q  <= 1'b0;
                    end
                end
                CONV: begin
                    par_q        <= bit_res;
                    bin_q[idx_q] <= bit_res;
                    if (idx_q != '0) begin
                        idx_q <= idx_q - 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.bin_out = bin_q;

endmodule
